// File: rtl/tuple_stream_compactor_pkg.sv
// Shared widths and types for the tuple stream compactor.
package tuple_stream_compactor_pkg;
    localparam int TUPLE_W   = 64;
    localparam int LANES     = 8;
    localparam int DATA_W    = LANES * TUPLE_W;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int BUF_LANES = 2 * LANES - 1;
    localparam int CNT_W     = 32;

    typedef logic [TUPLE_W-1:0]            tuple_t;
    typedef logic [$clog2(2*LANES)-1:0]    lane_cnt_t;

    function automatic lane_cnt_t min_lanes(input lane_cnt_t c);
        return (c >= lane_cnt_t'(LANES)) ? lane_cnt_t'(LANES) : c;
    endfunction
endpackage

// File: rtl/tuple_stream_compactor_if.sv
// Stream bus (data/keep/valid/last/ready) used on both sides of the compactor.
interface tuple_stream_compactor_if;
    import tuple_stream_compactor_pkg::*;

    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              valid;
    logic              last;
    logic              ready;

    modport master (output data, keep, valid, last, input ready);
    modport slave  (input data, keep, valid, last, output ready);
endinterface

// File: rtl/tuple_stream_compactor_lane_compactor.sv
// Combinational lane compactor: moves keep-valid lanes down to lane 0 in order
// and reports how many there were.
module lane_compactor
    import tuple_stream_compactor_pkg::*;
(
    input  logic [DATA_W-1:0]  i_data,
    input  logic [KEEP_W-1:0]  i_keep,
    output tuple_t [LANES-1:0] o_lanes,
    output lane_cnt_t          o_k,
    output logic               o_partial
);
    localparam int IDX_W = $clog2(LANES);

    logic [LANES-1:0] w_valid;
    logic [LANES-1:0] w_partial;
    lane_cnt_t        w_cnt;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_valid[i]   = &i_keep[i*8 +: 8];
            w_partial[i] = (|i_keep[i*8 +: 8]) & ~(&i_keep[i*8 +: 8]);
        end
    end

    // Running prefix count of valid lanes gives each valid lane its dense slot.
    always_comb begin
        o_lanes = '0;
        w_cnt   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_valid[i]) begin
                o_lanes[w_cnt[IDX_W-1:0]] = i_data[i*TUPLE_W +: TUPLE_W];
                w_cnt = w_cnt + lane_cnt_t'(1);
            end
        end
    end

    assign o_k       = w_cnt;
    assign o_partial = |w_partial;
endmodule

// File: rtl/tuple_stream_compactor.sv
// Packs sparse 64-bit tuple lanes into dense 512-bit beats; only the last beat of a packet is partial.
// Optional statistics counters are enabled by defining TUPLE_COMPACT_STATS_EN.
module tuple_stream_compactor
    import tuple_stream_compactor_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    tuple_stream_compactor_if.slave  i_s,
    tuple_stream_compactor_if.master o_m
`ifdef TUPLE_COMPACT_STATS_EN
    ,
    output logic [CNT_W-1:0]         stat_tuples_in,
    output logic [CNT_W-1:0]         stat_beats_out,
    output logic [CNT_W-1:0]         stat_packets
`endif
);
    localparam int BUF_W = BUF_LANES * TUPLE_W;

    // state     | meaning
    // ST_STREAM | accepting input, emitting only full beats
    // ST_FLUSH  | packet end taken; drain remainder, close with last, input held off
    typedef enum logic {ST_STREAM, ST_FLUSH} state_t;

    state_t             r_state, w_state_nxt;
    logic [BUF_W-1:0]   r_buf, w_buf_nxt;
    lane_cnt_t          r_cnt, w_cnt_nxt, w_take, w_remain, w_k;
    tuple_t [LANES-1:0] w_dense;
    logic [KEEP_W-1:0]  w_keep;
    logic               r_drained;
    logic               w_flush, w_acc, w_fire, w_out_valid, w_out_last, w_partial;

    lane_compactor u_lane_compactor (
        .i_data    (i_s.data),
        .i_keep    (i_s.keep),
        .o_lanes   (w_dense),
        .o_k       (w_k),
        .o_partial (w_partial)
    );

    assign w_flush     = (r_state == ST_FLUSH);
    assign w_out_valid = (r_cnt >= lane_cnt_t'(LANES)) || (w_flush && !r_drained);
    assign w_out_last  = w_flush && (r_cnt <= lane_cnt_t'(LANES));
    assign w_fire      = w_out_valid && o_m.ready;
    // out_ready feeds in_ready so a full buffer can drain and refill in the same cycle.
    assign i_s.ready   = !w_flush && ((r_cnt < lane_cnt_t'(LANES)) || o_m.ready);
    assign w_acc       = i_s.valid && i_s.ready;

    assign w_take    = w_fire ? min_lanes(r_cnt) : '0;
    assign w_remain  = r_cnt - w_take;
    assign w_cnt_nxt = w_remain + (w_acc ? w_k : '0);

    // Lanes above cnt are kept at zero, so appending is a plain OR.
    always_comb begin
        w_buf_nxt = r_buf >> (w_take * TUPLE_W);
        if (w_acc) begin
            w_buf_nxt = w_buf_nxt | (BUF_W'(w_dense) << (w_remain * TUPLE_W));
        end
    end

    always_comb begin
        w_keep = '0;
        for (int j = 0; j < LANES; j++) begin
            w_keep[j*8 +: 8] = {8{lane_cnt_t'(j) < r_cnt}};
        end
    end

    assign o_m.data  = r_buf[DATA_W-1:0];
    assign o_m.keep  = w_keep;
    assign o_m.valid = w_out_valid;
    assign o_m.last  = w_out_last;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STREAM: if (w_acc && i_s.last)     w_state_nxt = ST_FLUSH;
            ST_FLUSH:  if (w_fire && w_out_last)  w_state_nxt = ST_STREAM;
            default:                              w_state_nxt = ST_STREAM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_STREAM;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_drained <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_acc && i_s.last) begin
                r_drained <= 1'b0;
            end else if (w_fire && w_out_last) begin
                r_drained <= 1'b1;
            end
        end
    end

    // Lanes with some but not all keep bits set are illegal and get dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_acc) begin
            assert (!w_partial);
        end
    end

`ifdef TUPLE_COMPACT_STATS_EN
    logic [CNT_W-1:0] r_stat_tuples_in, r_stat_beats_out, r_stat_packets;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_tuples_in <= '0;
            r_stat_beats_out <= '0;
            r_stat_packets   <= '0;
        end else begin
            if (w_acc)                r_stat_tuples_in <= r_stat_tuples_in + CNT_W'(w_k);
            if (w_fire)               r_stat_beats_out <= r_stat_beats_out + CNT_W'(1);
            if (w_fire && w_out_last) r_stat_packets   <= r_stat_packets + CNT_W'(1);
        end
    end

    assign stat_tuples_in = r_stat_tuples_in;
    assign stat_beats_out = r_stat_beats_out;
    assign stat_packets   = r_stat_packets;
`endif
endmodule

// File: tb/tb_tuple_stream_compactor.sv
// Self-checking bench for tuple_stream_compactor: directed and random packets against a tuple-queue model.
// Define TUPLE_COMPACT_STATS_EN to also exercise the statistics counters.
module tb_tuple_stream_compactor;
    import tuple_stream_compactor_pkg::*;

    typedef struct {
        int n;
        bit last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    tuple_stream_compactor_if in_if ();
    tuple_stream_compactor_if out_if ();

`ifdef TUPLE_COMPACT_STATS_EN
    logic [CNT_W-1:0] stat_tuples_in, stat_beats_out, stat_packets;
`endif

    tuple_stream_compactor u_dut (
        .clk (clk),
        .rst (rst),
        .i_s (in_if),
        .o_m (out_if)
`ifdef TUPLE_COMPACT_STATS_EN
        ,
        .stat_tuples_in (stat_tuples_in),
        .stat_beats_out (stat_beats_out),
        .stat_packets   (stat_packets)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int max_tries;
    bit done;

    beat_t  exp_beats[$];
    tuple_t exp_tuples[$];
    int     fire_cyc[$];

    logic [DATA_W-1:0] pkt_data[8];
    logic [7:0]        pkt_mask[8];
    int                pkt_len;

    int                m_cnt;
    bit                m_flush;
    bit                prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic [KEEP_W-1:0] prev_keep;
    logic              prev_last;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [KEEP_W-1:0] keep_of(input logic [7:0] m);
        keep_of = '0;
        for (int l = 0; l < LANES; l++) keep_of[l*8 +: 8] = {8{m[l]}};
    endfunction

    function automatic logic [7:0] lanes_mask(input int n);
        return 8'((1 << n) - 1);
    endfunction

    function automatic logic [7:0] rand_mask();
        case ($urandom_range(0, 3))
            0:       return 8'hFF;
            1:       return 8'h00;
            default: return 8'($urandom());
        endcase
    endfunction

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [7:0] m, input logic l, output int tries);
        bit taken = 1'b0;
        in_if.data  = d;
        in_if.keep  = keep_of(m);
        in_if.last  = l;
        in_if.valid = 1'b1;
        tries = 0;
        while (!taken && tries < 300) begin
            @(negedge clk);
            taken = in_if.ready;
            tries++;
            @(posedge clk);
            #1;
        end
        if (!taken) chk("accept_timeout", 32'(taken), 1);
        in_if.valid = 1'b0;
        in_if.keep  = '0;
        in_if.last  = 1'b0;
        in_if.data  = '0;
    endtask

    // Expected beats: every full group of 8 before the last input beat goes out unmarked;
    // the leftover plus the last beat's tuples form one or two closing beats (at least one).
    task automatic run_packet();
        int t = 0;
        int klast = 0;
        int r;
        int tries;
        for (int b = 0; b < pkt_len; b++) begin
            for (int w = 0; w < DATA_W / 32; w++) pkt_data[b][w*32 +: 32] = $urandom();
            for (int l = 0; l < LANES; l++) begin
                if (pkt_mask[b][l]) begin
                    exp_tuples.push_back(pkt_data[b][l*TUPLE_W +: TUPLE_W]);
                    if (b == pkt_len - 1) klast++;
                    else t++;
                end
            end
        end
        repeat (t / LANES) exp_beats.push_back('{LANES, 1'b0});
        r = (t % LANES) + klast;
        if (r > LANES) begin
            exp_beats.push_back('{LANES, 1'b0});
            exp_beats.push_back('{r - LANES, 1'b1});
        end else begin
            exp_beats.push_back('{r, 1'b1});
        end
        for (int b = 0; b < pkt_len; b++) begin
            send_beat(pkt_data[b], pkt_mask[b], (b == pkt_len - 1), tries);
            if (tries > max_tries) max_tries = tries;
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_beats.size() != 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain_beats", exp_beats.size(), 0);
        chk("drain_tuples", exp_tuples.size(), 0);
    endtask

    always @(negedge clk) begin
        beat_t             eb;
        logic [DATA_W-1:0] ed, mask;
        int                take, k;
        bit                acc, fire;
        cyc++;
        if (rst) begin
            m_cnt      = 0;
            m_flush    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", in_if.ready, (!m_flush && (m_cnt < LANES || out_if.ready)));
            chk("out_valid", out_if.valid, (m_cnt >= LANES || m_flush));
            if (prev_stall) begin
                chk("hold_valid", out_if.valid, 1);
                chk("hold_data", out_if.data, prev_data);
                chk("hold_keep", out_if.keep, prev_keep);
                chk("hold_last", out_if.last, prev_last);
            end
            fire = out_if.valid && out_if.ready;
            acc  = in_if.valid && in_if.ready;
            take = 0;
            if (fire) begin
                fire_cyc.push_back(cyc);
                if (exp_beats.size() == 0) begin
                    chk("beat_unexpected", fire, 0);
                end else begin
                    eb   = exp_beats.pop_front();
                    ed   = '0;
                    mask = '0;
                    for (int j = 0; j < eb.n; j++) begin
                        ed[j*TUPLE_W +: TUPLE_W]   = exp_tuples.pop_front();
                        mask[j*TUPLE_W +: TUPLE_W] = '1;
                    end
                    chk("out_keep", out_if.keep, keep_of(lanes_mask(eb.n)));
                    chk("out_last", out_if.last, eb.last);
                    chk("out_data", out_if.data & mask, ed);
                    take = eb.n;
                    if (eb.last) m_flush = 1'b0;
                end
            end
            k = 0;
            if (acc) begin
                for (int l = 0; l < LANES; l++) if (&in_if.keep[l*8 +: 8]) k++;
            end
            m_cnt = m_cnt - take + k;
            if (acc && in_if.last) m_flush = 1'b1;
            prev_stall = out_if.valid && !out_if.ready;
            prev_data  = out_if.data;
            prev_keep  = out_if.keep;
            prev_last  = out_if.last;
        end
    end

    initial begin
        int tries;
        rst          = 1'b1;
        in_if.data   = '0;
        in_if.keep   = '0;
        in_if.valid  = 1'b0;
        in_if.last   = 1'b0;
        out_if.ready = 1'b1;
        max_tries    = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_out_last", out_if.last, 0);
        chk("rst_out_keep", out_if.keep, 0);
        chk("rst_out_data", out_if.data, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_if.ready, 1);

        // full throughput: 4 dense beats
        fire_cyc.delete();
        max_tries = 0;
        pkt_len = 4;
        for (int b = 0; b < 4; b++) pkt_mask[b] = 8'hFF;
        run_packet();
        wait_drain();
        chk("thru_no_stall", max_tries, 1);
        chk("thru_beats", fire_cyc.size(), 4);
        if (fire_cyc.size() == 4) chk("thru_consecutive", fire_cyc[3] - fire_cyc[0], 3);

        // sparse packing 0x0F, 0xF0, 0x81
        pkt_len = 3;
        pkt_mask[0] = 8'h0F;
        pkt_mask[1] = 8'hF0;
        pkt_mask[2] = 8'h81;
        run_packet();
        wait_drain();

        // empty packet
        pkt_len = 1;
        pkt_mask[0] = 8'h00;
        run_packet();
        wait_drain();

        // full beat then empty last beat: closing beat with keep 0
        pkt_len = 2;
        pkt_mask[0] = 8'hFF;
        pkt_mask[1] = 8'h00;
        run_packet();
        wait_drain();

        // zero-lane beat mid-packet is absorbed
        pkt_len = 2;
        pkt_mask[0] = 8'h00;
        pkt_mask[1] = 8'h07;
        run_packet();
        wait_drain();

        // buffer reaches 15 lanes at packet end
        pkt_len = 2;
        pkt_mask[0] = 8'h7F;
        pkt_mask[1] = 8'hFF;
        run_packet();
        wait_drain();

        // backpressure: out_ready low for 10 cycles mid-packet
        pkt_len = 4;
        pkt_mask[0] = 8'hFF;
        for (int b = 1; b < 4; b++) pkt_mask[b] = rand_mask();
        fork
            run_packet();
            begin
                repeat (2) @(posedge clk);
                #1;
                out_if.ready = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                out_if.ready = 1'b1;
            end
        join
        wait_drain();

        // random packets with random backpressure
        done = 1'b0;
        fork
            begin
                for (int p = 0; p < 15; p++) begin
                    pkt_len = $urandom_range(1, 5);
                    for (int b = 0; b < pkt_len; b++) pkt_mask[b] = rand_mask();
                    run_packet();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_if.ready = ($urandom_range(0, 3) != 0);
                end
                out_if.ready = 1'b1;
            end
        join
        wait_drain();

        // reset with 5 tuples buffered, then a clean packet
        for (int w = 0; w < DATA_W / 32; w++) pkt_data[0][w*32 +: 32] = $urandom();
        send_beat(pkt_data[0], 8'h1F, 1'b0, tries);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_if.valid, 0);
        chk("midrst_out_keep", out_if.keep, 0);
        chk("midrst_out_data", out_if.data, 0);
        chk("midrst_out_last", out_if.last, 0);
        exp_beats.delete();
        exp_tuples.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_if.ready, 1);
        pkt_len = 1;
        pkt_mask[0] = 8'h07;
        run_packet();
        wait_drain();

`ifdef TUPLE_COMPACT_STATS_EN
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pkt_len = 2;
        pkt_mask[0] = 8'hFF;
        pkt_mask[1] = 8'h03;
        run_packet();
        pkt_len = 1;
        pkt_mask[0] = 8'h07;
        run_packet();
        wait_drain();
        chk("stat_tuples_in", stat_tuples_in, 13);
        chk("stat_beats_out", stat_beats_out, 3);
        chk("stat_packets", stat_packets, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tuple_stream_compactor.md
Name: tuple_stream_compactor

Overview:
- Sits directly downstream of the 1024-to-512 width converter, between the partitioned hash-join output and the host send stream.
- Join output beats carry sparse 64-bit result tuples; tkeep has holes at 8-byte lane granularity.
- Packs valid lanes into dense 512-bit beats so that only the final beat of a packet is partial. This cuts host-side beat count and bandwidth.

Parameters:
- DATA_W, 512, stream data width in bits.
- TUPLE_W, 64, tuple (lane) width in bits; LANES = DATA_W/TUPLE_W = 8.
- CNT_W, 32, width of statistics counters (optional feature only).

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  input beat; lane i = bits [i*TUPLE_W +: TUPLE_W].
- in_keep  in  DATA_W/8  byte enables; lane valid iff all 8 of its keep bits are set.
- in_valid  in  1  input beat valid.
- in_last  in  1  last beat of packet.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- out_data  out  DATA_W  packed beat; valid lanes contiguous from lane 0.
- out_keep  out  DATA_W/8  byte enables; contiguous low lanes only.
- out_valid  out  1  output beat valid.
- out_last  out  1  last beat of packet.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): buffer count = 0, flush_pending = 0. out_valid, out_last, out_keep and out_data are all 0. in_ready is 1 after release.
- Internal buffer of 2*LANES-1 = 15 lanes. cnt (4 bits) = number of occupied lanes, packed from lane 0.
- Accept: k = number of valid lanes in the accepted beat. Valid lanes are compacted in ascending lane order and appended at buffer positions cnt..cnt+k-1. Invalid lanes are discarded.
- Lanes with partial keep (some but not all 8 bits set) are illegal input. The lane is treated as invalid. A simulation assertion fires.
- out_valid = (cnt >= 8) || (flush_pending && !drained).
- out_data = buffer lanes 0..7.
- out_keep lane j is set iff j < min(cnt, 8).
- out_last = flush_pending && cnt <= 8.
- Output fire (out_valid && out_ready): remove min(cnt, 8) lanes and shift the remainder down to lane 0. If out_last, clear flush_pending and set drained.
- in_ready = !flush_pending && (cnt <= 7 || (cnt >= 8 && out_ready)). This combinational path from out_ready is intentional: it gives full throughput (one dense beat per cycle with all-valid input).
- Simultaneous accept and fire: new cnt = cnt - min(cnt,8) + k. This never exceeds 15.
- Latency: minimum 1 cycle from accept to visibility on out_* (buffer is registered). No combinational path from in_* to out_*.
- in_last accepted: set flush_pending. in_ready stays low until the final beat fires.
- Last beat of a packet that leaves cnt = 0 (including empty packets): emit exactly one beat with keep = 0 and last = 1. The packet end is never swallowed.
- Zero-lane beat without last: absorbed, no output, no stall.
- Output stability: out_* stay stable while out_valid && !out_ready (AXI-Stream rules).
- Mid-operation reset: buffered tuples are discarded and the next packet starts clean. No partial-beat emission.

Optional Feature:
- Macro TUPLE_COMPACT_STATS_EN.
- Defined: adds output ports stat_tuples_in (CNT_W), stat_beats_out (CNT_W) and stat_packets (CNT_W).
  - Counters are cleared by rst and wrap at 2^CNT_W.
  - stat_tuples_in += k on each accept.
  - stat_beats_out += 1 on each fire.
  - stat_packets += 1 on each fire with out_last.
- Undefined: ports and logic are absent; datapath behaviour is identical.

Decomposition:
- Shared package holds: TUPLE_W, LANES, tuple_t (logic [TUPLE_W-1:0]) and lane_cnt_t.
- One sub-module, lane_compactor: purely combinational. Takes in_data/in_keep, outputs a dense LANES-lane vector plus the count k, using a prefix-sum over lane-valid bits.
- Buffer, append/shift and the flush state machine stay in the top module.

Test Plan:
- Full-throughput path: 4 beats, all lanes valid, last on beat 4, out_ready = 1 -> 4 output beats on consecutive cycles, keep all-ones, last on beat 4, in_ready never drops.
- Sparse packing: beats with lane masks 0x0F, 0xF0, 0x81, last on the third beat -> 10 tuples total. Expect beat 1 = 8 tuples in order (lanes 0-3 of beat A, 4-7 of B); beat 2 keep = 0xFFFF (lanes 0-1), last = 1.
- Empty packet: single beat with keep = 0, last = 1 -> one output beat with keep = 0, last = 1.
- Backpressure: out_ready low for 10 cycles mid-packet, random masks -> out_* hold stable. No tuple lost or duplicated against a scoreboard. in_ready low while cnt >= 8.
- Reset mid-packet: assert rst with cnt = 5 -> outputs 0 immediately. The next packet's output contains no stale tuples.
- With TUPLE_COMPACT_STATS_EN defined: two packets of 10 and 3 tuples -> stat_tuples_in = 13, stat_beats_out = 3, stat_packets = 2.
